// File: rtl/vga_frame_packer.sv
// Game-object register file and packet multiplexer feeding the VGA controller's data_in word.
// Define VGA_PACKER_SHADOW_EN to buffer CPU writes and commit them atomically on each frame tick.
module vga_frame_packer #(
  parameter int ROAD_ROWS   = 240,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk_cpu,
  input  logic                   sys_rst_n,
  input  logic                   wr_en,
  input  logic [1:0]             wr_addr,
  input  logic [31:0]            wr_data,
  input  logic                   vsync_in,
  output logic [31:0]            vga_data,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {S_USER, S_ENEMY, S_ROAD} slot_t;

  typedef struct packed {
    logic [10:0] ux;
    logic [10:0] uy;
    logic [10:0] ex;
    logic [10:0] ey;
    logic [1:0]  gs;
    logic [3:0]  step;
  } regs_t;

  localparam logic [1:0]  GS_READY  = 2'b00;
  localparam logic [1:0]  GS_DURING = 2'b01;
  localparam logic [11:0] ROWS_L    = 12'(ROAD_ROWS);

  slot_t       slot;
  regs_t       act_r;
  regs_t       in_r;
  regs_t       nxt_r;
  logic [10:0] road_margin;
  logic [11:0] margin_sum;
  logic [11:0] margin_wrap;
  logic        vs_meta;
  logic        vs_sync;
  logic        vs_prev;
  logic        frame_tick;
  logic        unused_wr_bits;

  assign unused_wr_bits = ^{wr_data[31:27], wr_data[15:11]};

  // vsync_in is from the pixel clock domain; two flops resynchronise, the third detects the fall.
  always_ff @(posedge clk_cpu or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= vsync_in;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign frame_tick = vs_prev & ~vs_sync;

`ifdef VGA_PACKER_SHADOW_EN
  regs_t pend_r;

  always_ff @(posedge clk_cpu or negedge sys_rst_n) begin
    if (!sys_rst_n) pend_r <= '0;
    else            pend_r <= in_r;
  end
`endif

  // in_r merges this cycle's write into the set it targets; nxt_r is what becomes active at the edge.
  always_comb begin
`ifdef VGA_PACKER_SHADOW_EN
    in_r = pend_r;
`else
    in_r = act_r;
`endif
    if (wr_en) begin
      case (wr_addr)
        2'd0: begin
          in_r.uy = wr_data[26:16];
          in_r.ux = wr_data[10:0];
        end
        2'd1: begin
          in_r.ey = wr_data[26:16];
          in_r.ex = wr_data[10:0];
        end
        2'd2: begin
          in_r.gs   = wr_data[1:0];
          in_r.step = wr_data[7:4];
        end
        default: ;
      endcase
    end
`ifdef VGA_PACKER_SHADOW_EN
    nxt_r = frame_tick ? in_r : act_r;
`else
    nxt_r = in_r;
`endif
  end

  assign margin_sum  = {1'b0, road_margin} + {8'b0, nxt_r.step};
  assign margin_wrap = margin_sum - ROWS_L;

  // Scroll decisions use nxt_r so a same-cycle control write (or commit) steers this tick.
  always_ff @(posedge clk_cpu or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      act_r       <= '0;
      road_margin <= '0;
      frame_cnt   <= '0;
    end else begin
      act_r <= nxt_r;
      if (frame_tick) frame_cnt <= frame_cnt + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
      if (nxt_r.gs == GS_READY) begin
        road_margin <= '0;
      end else if (frame_tick && nxt_r.gs == GS_DURING) begin
        road_margin <= (margin_sum >= ROWS_L) ? margin_wrap[10:0] : margin_sum[10:0];
      end
    end
  end

  always_ff @(posedge clk_cpu or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot     <= S_USER;
      vga_data <= '0;
    end else begin
      case (slot)
        S_USER: begin
          vga_data <= {2'b01, act_r.gs, act_r.uy, act_r.ux, 6'b0};
          slot     <= S_ENEMY;
        end
        S_ENEMY: begin
          vga_data <= {2'b10, act_r.gs, act_r.ey, act_r.ex, 6'b0};
          slot     <= S_ROAD;
        end
        S_ROAD: begin
          vga_data <= {2'b11, act_r.gs, road_margin, 11'b0, 6'b0};
          slot     <= S_USER;
        end
        default: begin
          vga_data <= '0;
          slot     <= S_USER;
        end
      endcase
    end
  end

endmodule
